// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle layout and stage record for the ID->EX/MEM/WB control pipeline.
package ctrl_pipe_pkg;

  localparam int CTRL_W_DEF   = 8;
  localparam int REG_W        = 5;

  localparam int REGWR_BIT    = 0;
  localparam int MEMRD_BIT    = 1;
  localparam int MEMWR_BIT    = 2;
  localparam int ALUSRC_BIT   = 3;
  localparam int MEMTOREG_BIT = 4;
  localparam int ALUOP_LSB    = 5;
  localparam int ALUOP_W      = 2;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [REG_W-1:0]      rd;
    logic                  valid;
  } stage_rec_t;

  // True when the instruction actually reads rs and rs names the producer's rd.
  function automatic logic src_hit(input logic use_en,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rd);
    return use_en & (rs == rd);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-pipeline register: hold keeps, bubble clears, otherwise loads the upstream record.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [REG_W-1:0]  rd_d,
  input  logic              valid_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [REG_W-1:0]  rd_q,
  output logic              valid_q
);

  logic [CTRL_W-1:0] ctrl_r, ctrl_nxt_s;
  logic [REG_W-1:0]  rd_r, rd_nxt_s;
  logic              valid_r, valid_nxt_s;

  // Next-record select with priority hold > bubble > load.
  always_comb begin
    ctrl_nxt_s  = ctrl_r;
    rd_nxt_s    = rd_r;
    valid_nxt_s = valid_r;
    if (hold_i) begin
      ctrl_nxt_s  = ctrl_r;
      rd_nxt_s    = rd_r;
      valid_nxt_s = valid_r;
    end else if (bubble_i) begin
      ctrl_nxt_s  = {CTRL_W{1'b0}};
      rd_nxt_s    = {REG_W{1'b0}};
      valid_nxt_s = 1'b0;
    end else begin
      ctrl_nxt_s  = ctrl_d;
      rd_nxt_s    = rd_d;
      valid_nxt_s = valid_d;
    end
  end

  // Stage register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_r  <= {CTRL_W{1'b0}};
      rd_r    <= {REG_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      ctrl_r  <= ctrl_nxt_s;
      rd_r    <= rd_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign ctrl_q  = ctrl_r;
  assign rd_q    = rd_r;
  assign valid_q = valid_r;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control-bundle pipeline from ID through DEPTH stages with EX load-use detection,
// bubble insertion, flush, global hold and a saturating bubble counter.
module ctrl_pipe_hazard #(
  parameter int CTRL_W    = ctrl_pipe_pkg::CTRL_W_DEF,
  parameter int DEPTH     = 3,
  parameter int REGWR_BIT = ctrl_pipe_pkg::REGWR_BIT,
  parameter int MEMRD_BIT = ctrl_pipe_pkg::MEMRD_BIT,
  parameter int CNT_W     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic                    valid_i,
  input  logic [4:0]              rd_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  input  logic                    rs1_use_i,
  input  logic                    rs2_use_i,
  input  logic                    flush_i,
  input  logic                    hold_i,
  output logic [DEPTH*CTRL_W-1:0] ctrl_o,
  output logic [DEPTH*5-1:0]      rd_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic                    stall_o,
  output logic [CNT_W-1:0]        bubble_cnt_o
);

  import ctrl_pipe_pkg::*;

  if (REGWR_BIT >= CTRL_W || MEMRD_BIT >= CTRL_W || DEPTH < 2) begin : g_param_check
    $error("ctrl_pipe_hazard: control bit index out of range or DEPTH below 2");
  end

  logic [CTRL_W-1:0] st_ctrl_s [DEPTH];
  logic [REG_W-1:0]  st_rd_s   [DEPTH];
  logic [DEPTH-1:0]  st_valid_s;

  logic [CTRL_W-1:0] id_ctrl_s;
  logic              load_use_s;
  logic              ins_bubble_s;
  logic [CNT_W-1:0]  bubble_cnt_r, cnt_nxt_s;

  // A non-valid ID slot must never carry live RegWrite/MemRead into EX.
  assign id_ctrl_s = valid_i ? ctrl_i : {CTRL_W{1'b0}};

  // Only EX is checked: a load there cannot forward in time to the ID reader.
  assign load_use_s = st_valid_s[0]
                    & st_ctrl_s[0][MEMRD_BIT]
                    & (st_rd_s[0] != 5'd0)
                    & valid_i
                    & (src_hit(rs1_use_i, rs1_i, st_rd_s[0]) |
                       src_hit(rs2_use_i, rs2_i, st_rd_s[0]));

  // Flush beats load-use, so the front end is free to redirect instead of stalling.
  assign ins_bubble_s = flush_i | load_use_s;
  assign stall_o      = hold_i | (load_use_s & ~flush_i);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      ctrl_pipe_stage #(.CTRL_W(CTRL_W)) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (hold_i),
        .bubble_i (ins_bubble_s),
        .ctrl_d   (id_ctrl_s),
        .rd_d     (rd_i),
        .valid_d  (valid_i),
        .ctrl_q   (st_ctrl_s[k]),
        .rd_q     (st_rd_s[k]),
        .valid_q  (st_valid_s[k])
      );
    end else begin : g_rest
      ctrl_pipe_stage #(.CTRL_W(CTRL_W)) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (hold_i),
        .bubble_i (1'b0),
        .ctrl_d   (st_ctrl_s[k-1]),
        .rd_d     (st_rd_s[k-1]),
        .valid_d  (st_valid_s[k-1]),
        .ctrl_q   (st_ctrl_s[k]),
        .rd_q     (st_rd_s[k]),
        .valid_q  (st_valid_s[k])
      );
    end

    assign ctrl_o[k*CTRL_W +: CTRL_W] = st_ctrl_s[k];
    assign rd_o[k*5 +: 5]             = st_rd_s[k];
  end

  assign valid_o = st_valid_s;

  // Saturating bubble counter; frozen during hold like every stage.
  always_comb begin
    cnt_nxt_s = bubble_cnt_r;
    if (!hold_i && ins_bubble_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      cnt_nxt_s = bubble_cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = bubble_cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      bubble_cnt_r <= cnt_nxt_s;
    end
  end

  assign bubble_cnt_o = bubble_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Self-checking bench: directed table, hold/saturation/async-reset sequences, and random
// stimulus against a queue-based model of the control pipeline.
module tb_ctrl_pipe_hazard;

  logic        clk;
  logic        rst_i;
  logic [7:0]  ctrl_i;
  logic        valid_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic        rs1_use_i, rs2_use_i, flush_i, hold_i;

  logic [23:0] ctrl_o, ctrl_o2;
  logic [14:0] rd_o, rd_o2;
  logic [2:0]  valid_o, valid_o2;
  logic        stall_o, stall_o2;
  logic [15:0] cnt_o;
  logic [1:0]  cnt_o2;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_hazard dut (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .valid_i(valid_i), .rd_i(rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_use_i(rs1_use_i), .rs2_use_i(rs2_use_i),
    .flush_i(flush_i), .hold_i(hold_i), .ctrl_o(ctrl_o), .rd_o(rd_o),
    .valid_o(valid_o), .stall_o(stall_o), .bubble_cnt_o(cnt_o)
  );

  ctrl_pipe_hazard #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .valid_i(valid_i), .rd_i(rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_use_i(rs1_use_i), .rs2_use_i(rs2_use_i),
    .flush_i(flush_i), .hold_i(hold_i), .ctrl_o(ctrl_o2), .rd_o(rd_o2),
    .valid_o(valid_o2), .stall_o(stall_o2), .bubble_cnt_o(cnt_o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] ctrl;
    logic [4:0] rd;
    logic       valid;
  } rec_t;

  rec_t m_pipe[$];
  int   m_cnt;

  typedef struct {
    logic v; logic [7:0] c; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic u1; logic u2; logic fl; logic hd;
    logic e_stall; logic [7:0] e_c0; logic [4:0] e_rd0; logic e_v0; int e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    b.ctrl = 8'h00; b.rd = 5'd0; b.valid = 1'b0;
    m_pipe = {};
    for (int k = 0; k < 3; k++) m_pipe.push_back(b);
    m_cnt = 0;
  endtask

  function automatic bit model_load_use();
    rec_t ex;
    ex = m_pipe[0];
    return ex.valid && ex.ctrl[1] && (ex.rd != 5'd0) && valid_i &&
           ((rs1_use_i && rs1_i == ex.rd) || (rs2_use_i && rs2_i == ex.rd));
  endfunction

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic fl, input logic hd);
    valid_i = v; ctrl_i = c; rd_i = rd; rs1_i = r1; rs2_i = r2;
    rs1_use_i = u1; rs2_use_i = u2; flush_i = fl; hold_i = hd;
  endtask

  task automatic compare_all();
    int sat;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ctrl[%0d]", k), 32'(ctrl_o[k*8 +: 8]), 32'(m_pipe[k].ctrl));
      chk($sformatf("rd[%0d]", k), 32'(rd_o[k*5 +: 5]), 32'(m_pipe[k].rd));
      chk($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(m_pipe[k].valid));
    end
    chk("bubble_cnt", 32'(cnt_o), 32'(m_cnt));
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("bubble_cnt_sat", 32'(cnt_o2), 32'(sat));
  endtask

  // One cycle: check combinational stall, clock, advance the model, check stages.
  task automatic step(output logic st_seen);
    bit   haz;
    logic exp_stall;
    rec_t nr;
    #1;
    haz = model_load_use();
    exp_stall = hold_i | (haz & ~flush_i);
    st_seen = stall_o;
    chk("stall", 32'(stall_o), 32'(exp_stall));
    @(posedge clk);
    if (!hold_i) begin
      if (flush_i || haz) begin
        nr.ctrl = 8'h00; nr.rd = 5'd0; nr.valid = 1'b0;
        m_cnt++;
      end else begin
        nr.ctrl = valid_i ? ctrl_i : 8'h00; nr.rd = rd_i; nr.valid = valid_i;
      end
      m_pipe.push_front(nr);
      void'(m_pipe.pop_back());
    end
    #1;
    compare_all();
  endtask

  logic st;

  initial begin
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    model_reset();
    #2;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset ctrl_o", 32'(ctrl_o), 32'd0);
    chk("reset cnt", 32'(cnt_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    //          v     c      rd     rs1    rs2    u1    u2    fl    hd    stall c0     rd0    v0    cnt
    tbl[0]  = '{1'b1, 8'h05, 5'd3,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 5'd3,  1'b1, 0};
    tbl[1]  = '{1'b0, 8'hFF, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  1'b0, 0};
    tbl[2]  = '{1'b1, 8'h03, 5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 5'd5,  1'b1, 0};
    tbl[3]  = '{1'b1, 8'h05, 5'd6,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0, 1};
    tbl[4]  = '{1'b1, 8'h05, 5'd6,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 5'd6,  1'b1, 1};
    tbl[5]  = '{1'b1, 8'h03, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 5'd0,  1'b1, 1};
    tbl[6]  = '{1'b1, 8'h01, 5'd7,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 5'd7,  1'b1, 1};
    tbl[7]  = '{1'b1, 8'h03, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 5'd9,  1'b1, 1};
    tbl[8]  = '{1'b1, 8'h01, 5'd4,  5'd0,  5'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0,  1'b0, 2};
    tbl[9]  = '{1'b1, 8'h03, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 5'd9,  1'b1, 2};
    tbl[10] = '{1'b1, 8'h01, 5'd4,  5'd9,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 5'd4,  1'b1, 2};
    tbl[11] = '{1'b0, 8'h03, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd9,  1'b0, 2};
    tbl[12] = '{1'b1, 8'h01, 5'd2,  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 5'd2,  1'b1, 2};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].u1, tbl[i].u2, tbl[i].fl, tbl[i].hd);
      step(st);
      chk($sformatf("tbl%0d stall", i), 32'(st), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d ctrl0", i), 32'(ctrl_o[7:0]), 32'(tbl[i].e_c0));
      chk($sformatf("tbl%0d rd0", i), 32'(rd_o[4:0]), 32'(tbl[i].e_rd0));
      chk($sformatf("tbl%0d valid0", i), 32'(valid_o[0]), 32'(tbl[i].e_v0));
      chk($sformatf("tbl%0d cnt", i), 32'(cnt_o), 32'(tbl[i].e_cnt));
    end

    // Fill the pipe, then hold for three cycles while flush and a would-be load arrive.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h01, 5'(10 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(st);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h03, 5'd20, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(st);
      chk("hold stall", 32'(st), 32'd1);
      chk("hold rd0", 32'(rd_o[4:0]), 32'd12);
      chk("hold rd2", 32'(rd_o[14:10]), 32'd10);
      chk("hold cnt", 32'(cnt_o), 32'd2);
    end

    // Five flushes: the narrow counter saturates at 3 and stays there.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h01, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(st);
    end
    chk("flush cnt", 32'(cnt_o), 32'd7);
    chk("sat cnt", 32'(cnt_o2), 32'd3);

    // Asynchronous reset between clock edges.
    drive(1'b1, 8'h05, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(st);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async valid_o", 32'(valid_o), 32'd0);
    chk("async ctrl_o", 32'(ctrl_o), 32'd0);
    chk("async rd_o", 32'(rd_o), 32'd0);
    chk("async cnt", 32'(cnt_o), 32'd0);
    chk("async cnt_sat", 32'(cnt_o2), 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b1;

    // Random traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) != 0), 8'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      step(st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
